// File: rtl/spi_word_master_if.sv
// Handshake and SPI pin bundle for spi_word_master.
// master: the serialiser itself; slave: the control logic / pins facing it.
interface spi_word_master_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [CS_W-1:0]   cs_sel;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rx_data;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic [NUM_CS-1:0] spi_cs_n;

    modport master (
        input  start, cs_sel, tx_data, spi_miso,
        output busy, done, err, rx_data, spi_sck, spi_mosi, spi_cs_n
    );

    modport slave (
        output start, cs_sel, tx_data, spi_miso,
        input  busy, done, err, rx_data, spi_sck, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_word_master.sv
// SPI mode-0 word master: full-duplex DATA_W-bit transfer to one of NUM_CS slaves,
// programmable SCK divider, start/busy/done handshake and MISO readback.
module spi_word_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_word_master_if.master bus
);
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CS_W:0]    CS_LIMIT = (CS_W + 1)'(NUM_CS);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-2:0] tx_q, tx_d;         // bits still to send after the MSB
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rx_data_q <= rx_data_d;
        end
    end

    // NOTE: every next-state signal gets a default up front so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rx_data_d = rx_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if ({1'b0, bus.cs_sel} < CS_LIMIT) begin
                        state_d = LEAD;
                        tx_d    = bus.tx_data[DATA_W-2:0];
                        mosi_d  = bus.tx_data[DATA_W-1];
                        cs_n_d  = ~(NUM_CS'(1) << bus.cs_sel);
                        busy_d  = 1'b1;
                        div_d   = '0;
                        bit_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.spi_miso};
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d  = 1'b0;
                        mosi_d = tx_q[DATA_W-2];
                        tx_d   = tx_q << 1;
                    end else begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.spi_miso};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) state_d = TRAIL;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            TRAIL: begin
                // Final SCK high phase; its closing edge drops SCK and releases CS together.
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                    cs_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_word_master.sv
// Directed bench for spi_word_master: three instances cover the default build,
// an out-of-range cs_sel reject (NUM_CS=3) and a 16-bit full-rate sweep.
module tb_spi_word_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_word_master_if #(.DATA_W(8),  .NUM_CS(2)) a_if ();
    spi_word_master_if #(.DATA_W(16), .NUM_CS(1)) b_if ();
    spi_word_master_if #(.DATA_W(8),  .NUM_CS(3)) c_if ();

    spi_word_master #(.DATA_W(8),  .CLK_DIV(2), .NUM_CS(2)) u_a (.clk(clk), .reset(reset), .bus(a_if.master));
    spi_word_master #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1)) u_b (.clk(clk), .reset(reset), .bus(b_if.master));
    spi_word_master #(.DATA_W(8),  .CLK_DIV(1), .NUM_CS(3)) u_c (.clk(clk), .reset(reset), .bus(c_if.master));

    // Mode-0 slave on instance a: MSB presented at CS fall, next bit after each SCK fall.
    logic [7:0] slv_word = 8'h00;
    logic [7:0] slv_sh = 8'h00;
    logic [1:0] cs_prev = 2'b11;
    logic       sck_prev = 1'b0;
    always @(a_if.spi_cs_n or a_if.spi_sck) begin
        if (a_if.spi_cs_n !== 2'b11 && cs_prev === 2'b11) slv_sh = slv_word;
        else if (sck_prev === 1'b1 && a_if.spi_sck === 1'b0 && a_if.spi_cs_n !== 2'b11)
            slv_sh = {slv_sh[6:0], 1'b0};
        cs_prev = a_if.spi_cs_n;
        sck_prev = a_if.spi_sck;
        a_if.spi_miso = slv_sh[7];
    end

    // MOSI as seen by a slave at each rising SCK.
    int          a_rise = 0;
    logic [7:0]  a_log = 8'h00;
    int          b_rise = 0;
    logic [15:0] b_log = 16'h0000;
    int          b_prev = 0;
    int          b_last = 0;
    always @(posedge a_if.spi_sck) begin
        a_rise++;
        a_log = {a_log[6:0], a_if.spi_mosi};
    end
    always @(posedge b_if.spi_sck) begin
        b_rise++;
        b_log = {b_log[14:0], b_if.spi_mosi};
        b_prev = b_last;
        b_last = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #2;
        total_cnt++;
        if ({a_if.busy, a_if.done, a_if.err, a_if.spi_sck, a_if.spi_mosi} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {a_if.busy, a_if.done, a_if.err, a_if.spi_sck, a_if.spi_mosi});
        else pass_cnt++;
        total_cnt++;
        if (a_if.rx_data !== 8'h00) $display("FAIL reset_rx: got %h want 00", a_if.rx_data);
        else pass_cnt++;
        total_cnt++;
        if (a_if.spi_cs_n !== 2'b11) $display("FAIL reset_cs_a: got %b want 11", a_if.spi_cs_n);
        else pass_cnt++;
        total_cnt++;
        if (b_if.spi_cs_n !== 1'b1 || b_if.busy !== 1'b0)
            $display("FAIL reset_b: got cs %b busy %b want 1 0", b_if.spi_cs_n, b_if.busy);
        else pass_cnt++;
        total_cnt++;
        if (c_if.spi_cs_n !== 3'b111) $display("FAIL reset_cs_c: got %b want 111", c_if.spi_cs_n);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n = 0;
        int low0 = 0;
        int r0 = a_rise;
        bit saw_cs1 = 1'b0;
        bit saw_err = 1'b0;
        slv_word = 8'hA5;
        a_if.cs_sel = 1'b0;
        a_if.tx_data = 8'h11;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        total_cnt++;
        if (a_if.busy !== 1'b1 || a_if.spi_cs_n !== 2'b10 || a_if.spi_mosi !== 1'b0)
            $display("FAIL basic_e0: got busy %b cs %b mosi %b want 1 10 0",
                     a_if.busy, a_if.spi_cs_n, a_if.spi_mosi);
        else pass_cnt++;
        if (a_if.spi_cs_n[0] === 1'b0) low0++;
        while (n < 100 && a_if.done !== 1'b1) begin
            tick();
            n++;
            if (n == 10) begin
                a_if.start = 1'b1;
                a_if.cs_sel = 1'b1;
                a_if.tx_data = 8'hFF;
            end
            if (n == 11) a_if.start = 1'b0;
            if (a_if.spi_cs_n[0] === 1'b0) low0++;
            if (a_if.spi_cs_n[1] !== 1'b1) saw_cs1 = 1'b1;
            if (a_if.err !== 1'b0) saw_err = 1'b1;
        end
        total_cnt++;
        if (n != 32) $display("FAIL basic_done_time: got %0d want 32", n);
        else pass_cnt++;
        total_cnt++;
        if (low0 != 32) $display("FAIL basic_cs_low: got %0d want 32", low0);
        else pass_cnt++;
        total_cnt++;
        if (a_if.rx_data !== 8'hA5) $display("FAIL basic_rx: got %h want a5", a_if.rx_data);
        else pass_cnt++;
        total_cnt++;
        if (a_log !== 8'h11 || a_rise - r0 != 8)
            $display("FAIL basic_mosi: got %h/%0d rises want 11/8", a_log, a_rise - r0);
        else pass_cnt++;
        total_cnt++;
        if (saw_cs1 || saw_err) $display("FAIL basic_busy_start: got cs1 %b err %b want 0 0", saw_cs1, saw_err);
        else pass_cnt++;
        total_cnt++;
        if ({a_if.spi_sck, a_if.spi_mosi, a_if.spi_cs_n, a_if.busy} !== 5'b00110)
            $display("FAIL basic_end_pins: got %b want 00110",
                     {a_if.spi_sck, a_if.spi_mosi, a_if.spi_cs_n, a_if.busy});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_if.done !== 1'b0 || a_if.busy !== 1'b0)
            $display("FAIL basic_done_pulse: got done %b busy %b want 0 0", a_if.done, a_if.busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int d1 = -1;
        int d2 = -1;
        logic [1:0] cs_e0, cs_d1, cs_d1p;
        logic [7:0] rx1, log1;
        cs_d1 = 2'bxx;
        cs_d1p = 2'bxx;
        rx1 = 8'hxx;
        log1 = 8'hxx;
        slv_word = 8'h5A;
        a_if.cs_sel = 1'b1;
        a_if.tx_data = 8'h3C;
        a_if.start = 1'b1;
        tick();
        cs_e0 = a_if.spi_cs_n;
        a_if.cs_sel = 1'b0;
        a_if.tx_data = 8'hC3;
        while (n < 200 && d2 < 0) begin
            tick();
            n++;
            if (a_if.done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = n;
                    rx1 = a_if.rx_data;
                    log1 = a_log;
                    cs_d1 = a_if.spi_cs_n;
                end else d2 = n;
            end
            if (d1 >= 0 && n == d1 + 1) begin
                cs_d1p = a_if.spi_cs_n;
                a_if.start = 1'b0;
            end
        end
        a_if.start = 1'b0;
        total_cnt++;
        if (cs_e0 !== 2'b01) $display("FAIL b2b_cs_first: got %b want 01", cs_e0);
        else pass_cnt++;
        total_cnt++;
        if (d1 != 32) $display("FAIL b2b_done1: got %0d want 32", d1);
        else pass_cnt++;
        total_cnt++;
        if (cs_d1 !== 2'b11 || cs_d1p !== 2'b10)
            $display("FAIL b2b_gap: got %b then %b want 11 then 10", cs_d1, cs_d1p);
        else pass_cnt++;
        total_cnt++;
        if (d2 < 0 || d2 - d1 != 33) $display("FAIL b2b_spacing: got %0d want 33", d2 - d1);
        else pass_cnt++;
        total_cnt++;
        if (log1 !== 8'h3C || a_log !== 8'hC3)
            $display("FAIL b2b_mosi: got %h,%h want 3c,c3", log1, a_log);
        else pass_cnt++;
        total_cnt++;
        if (rx1 !== 8'h5A || a_if.rx_data !== 8'h5A)
            $display("FAIL b2b_rx: got %h,%h want 5a,5a", rx1, a_if.rx_data);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reject();
        int n = 0;
        c_if.cs_sel = 2'd3;
        c_if.start = 1'b1;
        tick();
        c_if.start = 1'b0;
        total_cnt++;
        if (c_if.err !== 1'b1) $display("FAIL reject_err: got %b want 1", c_if.err);
        else pass_cnt++;
        total_cnt++;
        if ({c_if.busy, c_if.spi_sck, c_if.spi_mosi, c_if.spi_cs_n} !== 6'b000111)
            $display("FAIL reject_quiet: got %b want 000111",
                     {c_if.busy, c_if.spi_sck, c_if.spi_mosi, c_if.spi_cs_n});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (c_if.err !== 1'b0 || c_if.busy !== 1'b0 || c_if.spi_cs_n !== 3'b111)
            $display("FAIL reject_after: got err %b busy %b cs %b want 0 0 111",
                     c_if.err, c_if.busy, c_if.spi_cs_n);
        else pass_cnt++;
        c_if.cs_sel = 2'd2;
        c_if.tx_data = 8'h81;
        c_if.start = 1'b1;
        tick();
        c_if.start = 1'b0;
        total_cnt++;
        if (c_if.busy !== 1'b1 || c_if.spi_cs_n !== 3'b011 || c_if.err !== 1'b0)
            $display("FAIL reject_top_cs: got busy %b cs %b err %b want 1 011 0",
                     c_if.busy, c_if.spi_cs_n, c_if.err);
        else pass_cnt++;
        while (n < 50 && c_if.done !== 1'b1) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n != 16 || c_if.rx_data !== 8'h00)
            $display("FAIL reject_top_done: got %0d/%h want 16/00", n, c_if.rx_data);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int r0 = a_rise;
        bit saw_done = 1'b0;
        slv_word = 8'h0F;
        a_if.cs_sel = 1'b0;
        a_if.tx_data = 8'h11;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        while (n < 100 && a_rise - r0 < 3) begin
            tick();
            n++;
        end
        total_cnt++;
        if (a_rise - r0 != 3) $display("FAIL mid_rises: got %0d want 3", a_rise - r0);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({a_if.spi_cs_n, a_if.spi_sck, a_if.spi_mosi, a_if.busy, a_if.done} !== 6'b110000)
            $display("FAIL mid_pins: got %b want 110000",
                     {a_if.spi_cs_n, a_if.spi_sck, a_if.spi_mosi, a_if.busy, a_if.done});
        else pass_cnt++;
        total_cnt++;
        if (a_if.rx_data !== 8'h00) $display("FAIL mid_rx: got %h want 00", a_if.rx_data);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done) $display("FAIL mid_no_done: got activity want none");
        else pass_cnt++;
        slv_word = 8'h3C;
        a_if.tx_data = 8'hFF;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        n = 0;
        while (n < 100 && a_if.done !== 1'b1) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n != 32 || a_if.rx_data !== 8'h3C || a_log !== 8'hFF)
            $display("FAIL mid_recover: got %0d/%h/%h want 32/3c/ff", n, a_if.rx_data, a_log);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_sweep();
        int n = 0;
        int low = 0;
        int r0 = b_rise;
        b_if.cs_sel = 1'b0;
        b_if.tx_data = 16'h8001;
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        if (b_if.spi_cs_n === 1'b0) low++;
        while (n < 100 && b_if.done !== 1'b1) begin
            tick();
            n++;
            if (b_if.spi_cs_n === 1'b0) low++;
        end
        total_cnt++;
        if (n != 32 || low != 32) $display("FAIL sweep_timing: got done %0d cs_low %0d want 32 32", n, low);
        else pass_cnt++;
        total_cnt++;
        if (b_rise - r0 != 16 || b_last - b_prev != 2)
            $display("FAIL sweep_sck: got %0d rises period %0d want 16 2", b_rise - r0, b_last - b_prev);
        else pass_cnt++;
        total_cnt++;
        if (b_log !== 16'h8001) $display("FAIL sweep_mosi: got %h want 8001", b_log);
        else pass_cnt++;
        total_cnt++;
        if (b_if.rx_data !== 16'hFFFF) $display("FAIL sweep_rx: got %h want ffff", b_if.rx_data);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        a_if.start = 1'b0;  a_if.cs_sel = '0;  a_if.tx_data = '0;
        b_if.start = 1'b0;  b_if.cs_sel = '0;  b_if.tx_data = '0;  b_if.spi_miso = 1'b1;
        c_if.start = 1'b0;  c_if.cs_sel = '0;  c_if.tx_data = '0;  c_if.spi_miso = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
